// File: rtl/pronoc_pkg.sv
// -----------------------------------------------------------------------------
// pronoc_pkg
// Shared types and helpers for the endpoint injection arbiter.
//   endp_arb_state_t : arbiter FSM state (IDLE = arbitrating, PKT = packet open)
//   flit_t           : flit record (hdr, tail, data) at the default flit width
//   credit_cnt_w()   : width of a credit counter that must hold 0..depth
//   rr_next()        : round-robin successor of an index, wrapping at n
// -----------------------------------------------------------------------------
package pronoc_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PKT  = 1'b1
  } endp_arb_state_t;

  localparam int FLIT_W_DEF       = 32;
  localparam int CREDIT_DEPTH_DEF = 4;
  localparam int CREDIT_CNT_W     = $clog2(CREDIT_DEPTH_DEF + 1);

  typedef struct packed {
    logic                  hdr;
    logic                  tail;
    logic [FLIT_W_DEF-1:0] data;
  } flit_t;

  // Counter must represent the full value 'depth', hence depth+1 states.
  function automatic int credit_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/endp_inject_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter_onehot
// Combinational round-robin pick: grants the first asserted request at or
// after the pointer, wrapping at NREQ.
// Ports:
//   i_req   [NREQ]  request vector
//   i_ptr   [PW]    highest-priority index this round
//   o_grant [NREQ]  onehot grant (all zero when no request)
// -----------------------------------------------------------------------------
module rr_arbiter_onehot
  import pronoc_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_grant
);

  localparam int PW = $clog2(NREQ);
  localparam int SW = PW + 1;

  logic [SW-1:0] w_raw;
  logic [PW-1:0] w_idx;
  logic          w_found;

  // Scan NREQ slots starting at the pointer; first hit wins.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_raw   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      // ptr + k < 2*NREQ, so a single conditional subtract is a full modulo.
      w_raw   = {1'b0, i_ptr} + SW'(k);
      w_idx   = PW'((w_raw >= SW'(NREQ)) ? (w_raw - SW'(NREQ)) : w_raw);
      o_grant[w_idx] = o_grant[w_idx] | (i_req[w_idx] & ~w_found);
      w_found = w_found | i_req[w_idx];
    end
  end

endmodule

// File: rtl/endp_inject_arbiter.sv
// -----------------------------------------------------------------------------
// endp_inject_arbiter
// Shares one router local-port injection channel between NREQ packet sources.
// Round-robin per packet; the grant is held from head to tail so flits of
// different packets never interleave. A flit is only accepted while a router
// input-buffer credit is available. Accepted flits appear on flit_out_* one
// cycle later.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/hdr/tail  per-requester flit present / head / tail flags
//   req_data            per-requester payload, requester i at [i*FLIT_W +: FLIT_W]
//   req_ready           per-requester accept strobe (combinational)
//   flit_out_*          registered flit towards the router
//   credit_in           one router buffer slot freed
//   owner               current/last granted requester
//   busy                packet in progress
//   credit_err          sticky: credit returned while counter already full
//   stat_pkt_cnt        (only with ENDP_INJ_ARB_STATS_EN) 16-bit wrapping tail
//                       count per requester, requester i at [i*16 +: 16]
//
// Optional feature macro: ENDP_INJ_ARB_STATS_EN
// -----------------------------------------------------------------------------
module endp_inject_arbiter
  import pronoc_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int FLIT_W       = 32,
  parameter int CREDIT_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_hdr,
  input  logic [NREQ-1:0]           req_tail,
  input  logic [NREQ*FLIT_W-1:0]    req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      flit_out_valid,
  output logic                      flit_out_hdr,
  output logic                      flit_out_tail,
  output logic [FLIT_W-1:0]         flit_out_data,
  input  logic                      credit_in,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy,
`ifdef ENDP_INJ_ARB_STATS_EN
  output logic [NREQ*16-1:0]        stat_pkt_cnt,
`endif
  output logic                      credit_err
);

  localparam int              PW       = $clog2(NREQ);
  localparam int              CW       = credit_cnt_w(CREDIT_DEPTH);
  localparam logic [CW-1:0]   CRED_MAX = CW'(CREDIT_DEPTH);

  typedef struct packed {
    logic              hdr;
    logic              tail;
    logic [FLIT_W-1:0] data;
  } flit_rec_t;

  endp_arb_state_t r_state;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   r_rr_ptr;
  logic            r_busy;
  logic [CW-1:0]   r_credits;
  logic            r_credit_err;
  logic            r_out_valid;
  flit_rec_t       r_out;

  logic [NREQ-1:0] w_cand;
  logic [NREQ-1:0] w_grant;
  logic [NREQ-1:0] w_ready;
  logic [PW-1:0]   w_winner;
  logic            w_any;
  logic            w_send;
  flit_rec_t       w_sel;

  assign w_cand = req_valid & req_hdr;
  assign w_any  = |w_cand;
  assign w_send = |w_ready;

  rr_arbiter_onehot #(
    .NREQ (NREQ)
  ) u_rr (
    .i_req   (w_cand),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant)
  );

  // Onehot grant to index.
  always_comb begin
    w_winner = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_winner = w_winner | (w_grant[i] ? PW'(i) : '0);
    end
  end

  // Only the packet owner may be accepted, and only with a credit in hand.
  always_comb begin
    w_ready = '0;
    if (r_state == PKT) begin
      w_ready[r_owner] = req_valid[r_owner] & (r_credits != '0);
    end else begin
      w_ready = '0;
    end
  end

  // Mux the owner's flit toward the output register.
  always_comb begin
    w_sel.hdr  = req_hdr[r_owner];
    w_sel.tail = req_tail[r_owner];
    w_sel.data = req_data[r_owner*FLIT_W +: FLIT_W];
  end

  // Arbitration FSM: pick in IDLE, hold the grant until the tail is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_busy   <= 1'b0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner <= w_winner;
            r_busy  <= 1'b1;
            r_state <= PKT;
          end
        end
        PKT: begin
          if (w_send && w_sel.tail) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_rr_ptr <= PW'(rr_next(32'(r_owner), 32'(NREQ)));
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Credit counter; a simultaneous send and return cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_credits    <= CRED_MAX;
      r_credit_err <= 1'b0;
    end else if (w_send && !credit_in) begin
      r_credits <= r_credits - CW'(1);
    end else if (!w_send && credit_in) begin
      if (r_credits == CRED_MAX) begin
        r_credit_err <= 1'b1;
      end else begin
        r_credits <= r_credits + CW'(1);
      end
    end
  end

  // Output register: one-cycle pulse per accepted flit, zeroed when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else begin
      r_out_valid <= w_send;
      r_out       <= w_send ? w_sel : '0;
    end
  end

`ifdef ENDP_INJ_ARB_STATS_EN
  logic [15:0] r_stat_cnt [NREQ];

  // Tail counter bumps on the edge the tail is registered onto flit_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        r_stat_cnt[i] <= 16'd0;
      end
    end else if (w_send && w_sel.tail) begin
      r_stat_cnt[r_owner] <= r_stat_cnt[r_owner] + 16'd1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign stat_pkt_cnt[g*16 +: 16] = r_stat_cnt[g];
  end
`endif

  assign req_ready      = w_ready;
  assign flit_out_valid = r_out_valid;
  assign flit_out_hdr   = r_out.hdr;
  assign flit_out_tail  = r_out.tail;
  assign flit_out_data  = r_out.data;
  assign owner          = r_owner;
  assign busy           = r_busy;
  assign credit_err     = r_credit_err;

endmodule

// File: tb/tb_endp_inject_arbiter.sv
// -----------------------------------------------------------------------------
// tb_endp_inject_arbiter
// Directed scoreboard bench for endp_inject_arbiter (NREQ=4, FLIT_W=32,
// CREDIT_DEPTH=4). Stimulus tasks fill per-requester flit queues and push the
// hand-ordered expected flit stream; a negedge driver presents queue heads, a
// monitor pops the scoreboard on every flit_out_valid.
// Payload encoding: {requester[7:0], packet[7:0], flit index[15:0]}.
// -----------------------------------------------------------------------------
module tb_endp_inject_arbiter;

  localparam int NREQ = 4;
  localparam int FW   = 32;

  typedef struct packed {
    logic          hdr;
    logic          tail;
    logic [FW-1:0] data;
  } fl_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid, req_hdr, req_tail, req_ready;
  logic [NREQ*FW-1:0]   req_data;
  logic                 flit_out_valid, flit_out_hdr, flit_out_tail;
  logic [FW-1:0]        flit_out_data;
  logic                 credit_in;
  logic [1:0]           owner;
  logic                 busy, credit_err;
`ifdef ENDP_INJ_ARB_STATS_EN
  logic [NREQ*16-1:0]   stat_pkt_cnt;
`endif

  endp_inject_arbiter #(.NREQ(NREQ), .FLIT_W(FW), .CREDIT_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_hdr        (req_hdr),
    .req_tail       (req_tail),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .flit_out_valid (flit_out_valid),
    .flit_out_hdr   (flit_out_hdr),
    .flit_out_tail  (flit_out_tail),
    .flit_out_data  (flit_out_data),
    .credit_in      (credit_in),
    .owner          (owner),
    .busy           (busy),
`ifdef ENDP_INJ_ARB_STATS_EN
    .stat_pkt_cnt   (stat_pkt_cnt),
`endif
    .credit_err     (credit_err)
  );

  always #5 clk = ~clk;

  fl_t rq[NREQ][$];
  fl_t exp_q[$];
  fl_t e;

  int  n_vec = 0;
  int  n_err = 0;
  int  n_out = 0;
  int  n_acc = 0;
  int  cyc = 0;
  int  prev_cyc = -1;
  logic prev_tail = 1'b0;
  logic rdy_seen = 1'b0;
  logic auto_credit = 1'b0;
  logic man_credit = 1'b0;
  logic strict = 1'b0;
  int  cred_on_acc = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic logic [FW-1:0] mkdata(input int r, input int p, input int k);
    return {8'(r), 8'(p), 16'(k)};
  endfunction

  task automatic add_stim(input int r, input int p, input int len);
    fl_t f;
    for (int k = 0; k < len; k++) begin
      f.hdr  = (k == 0);
      f.tail = (k == len - 1);
      f.data = mkdata(r, p, k);
      rq[r].push_back(f);
    end
  endtask

  task automatic add_exp(input int r, input int p, input int len);
    fl_t f;
    for (int k = 0; k < len; k++) begin
      f.hdr  = (k == 0);
      f.tail = (k == len - 1);
      f.data = mkdata(r, p, k);
      exp_q.push_back(f);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      cycles(1);
      c++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d flits still outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    exp_q.delete();
    auto_credit = 1'b0;
    man_credit  = 1'b0;
    strict      = 1'b0;
    cred_on_acc = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_stim();
    cycles(1);
    reset    = 1'b0;
    n_out    = 0;
    n_acc    = 0;
    prev_cyc = -1;
  endtask

  task automatic pulse_credit();
    man_credit = 1'b1;
    cycles(1);
    man_credit = 1'b0;
  endtask

  // Driver: present queue heads on the falling edge, then note what is accepted.
  always @(negedge clk) begin
    credit_in = (auto_credit && flit_out_valid) || man_credit;
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_hdr[i]           = rq[i][0].hdr;
        req_tail[i]          = rq[i][0].tail;
        req_data[i*FW +: FW] = rq[i][0].data;
      end else begin
        req_valid[i]         = 1'b0;
        req_hdr[i]           = 1'b0;
        req_tail[i]          = 1'b0;
        req_data[i*FW +: FW] = '0;
      end
    end
    #1;
    rdy_seen = |req_ready;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        if (rq[i].size() > 0) void'(rq[i].pop_front());
        n_acc++;
        if (n_acc == cred_on_acc) credit_in = 1'b1;
      end
    end
  end

  // Monitor: check every output flit against the scoreboard and its timing.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!reset) begin
      if (rdy_seen || flit_out_valid) chk("latency1", 64'(flit_out_valid), 64'(rdy_seen));
      if (flit_out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_flit: got data %0h, required no flit", flit_out_data);
        end else begin
          e = exp_q.pop_front();
          chk("flit", 64'({flit_out_hdr, flit_out_tail, flit_out_data}), 64'(e));
        end
        if (strict && prev_cyc >= 0)
          chk("spacing", 64'(cyc - prev_cyc), prev_tail ? 64'd2 : 64'd1);
        prev_cyc  = cyc;
        prev_tail = flit_out_tail;
        n_out++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_hdr   = '0;
    req_tail  = '0;
    req_data  = '0;
    credit_in = 1'b0;
    cycles(3);

    // Reset state
    chk("rst_valid", 64'(flit_out_valid), 64'd0);
    chk("rst_hdr_tail", 64'({flit_out_hdr, flit_out_tail}), 64'd0);
    chk("rst_data", 64'(flit_out_data), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_credit_err", 64'(credit_err), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    reset = 1'b0;

    // T1: four single-flit packets from req0, credit returned per flit
    auto_credit = 1'b1;
    strict      = 1'b1;
    for (int p = 0; p < 4; p++) begin
      add_stim(0, p, 1);
      add_exp(0, p, 1);
    end
    wait_drain(40);
    chk("t1_count", 64'(n_out), 64'd4);
    chk("t1_busy", 64'(busy), 64'd0);

    // T2: all four requesters with 3-flit packets, req0 holds a second one
    do_reset();
    auto_credit = 1'b1;
    strict      = 1'b1;
    add_stim(0, 0, 3);
    add_stim(0, 1, 3);
    add_stim(1, 0, 3);
    add_stim(2, 0, 3);
    add_stim(3, 0, 3);
    add_exp(0, 0, 3);
    add_exp(1, 0, 3);
    add_exp(2, 0, 3);
    add_exp(3, 0, 3);
    add_exp(0, 1, 3);
    wait_drain(60);
    cycles(3);
    chk("t2_count", 64'(n_out), 64'd15);
    chk("t2_busy", 64'(busy), 64'd0);
    chk("t2_owner", 64'(owner), 64'd0);
    chk("t2_credit_err", 64'(credit_err), 64'd0);

    // T3: no credits returned, 6-flit packet stalls after 4 flits
    do_reset();
    add_stim(1, 0, 6);
    add_exp(1, 0, 6);
    cycles(15);
    chk("t3_stall_count", 64'(n_out), 64'd4);
    chk("t3_stall_busy", 64'(busy), 64'd1);
    chk("t3_owner", 64'(owner), 64'd1);
    pulse_credit();
    pulse_credit();
    wait_drain(20);
    cycles(2);
    chk("t3_count", 64'(n_out), 64'd6);
    chk("t3_busy", 64'(busy), 64'd0);

    // T4: credit returned on the same edge the 4th flit is taken (credits=1)
    do_reset();
    strict      = 1'b1;
    cred_on_acc = 4;
    add_stim(2, 0, 5);
    add_exp(2, 0, 5);
    wait_drain(30);
    chk("t4_count", 64'(n_out), 64'd5);
    chk("t4_owner", 64'(owner), 64'd2);
    chk("t4_busy", 64'(busy), 64'd0);

    // T5: refill to 4 credits, one extra return sets the sticky error
    strict      = 1'b0;
    cred_on_acc = -1;
    prev_cyc    = -1;
    for (int i = 0; i < 4; i++) pulse_credit();
    cycles(2);
    chk("t5_no_err", 64'(credit_err), 64'd0);
    pulse_credit();
    cycles(1);
    chk("t5_err", 64'(credit_err), 64'd1);
    n_out = 0;
    add_stim(3, 0, 6);
    add_exp(3, 0, 6);
    cycles(15);
    chk("t5_credits_4", 64'(n_out), 64'd4);
    chk("t5_busy", 64'(busy), 64'd1);
    chk("t5_err_sticky", 64'(credit_err), 64'd1);

    // T6: reset after flit 2 of a 5-flit packet
    do_reset();
    chk("t6_err_cleared", 64'(credit_err), 64'd0);
    add_stim(1, 0, 5);
    add_exp(1, 0, 5);
    begin
      int c = 0;
      while (n_out < 2 && c < 20) begin
        cycles(1);
        c++;
      end
    end
    chk("t6_two_flits", 64'(n_out), 64'd2);
    reset = 1'b1;
    clear_stim();
    cycles(1);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_owner", 64'(owner), 64'd0);
    chk("t6_valid", 64'(flit_out_valid), 64'd0);
    chk("t6_no_third", 64'(n_out), 64'd2);
    reset    = 1'b0;
    n_out    = 0;
    n_acc    = 0;
    prev_cyc = -1;
    add_stim(2, 1, 6);
    add_exp(2, 1, 6);
    cycles(15);
    chk("t6_credits_4", 64'(n_out), 64'd4);
    chk("t6_busy_after", 64'(busy), 64'd1);
    chk("t6_owner_after", 64'(owner), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
